// File: rtl/btb_pkg.sv
// Shared types and constants for the gshare predictor and its target buffer.
package btb_pkg;

  localparam int DEF_INDEX_BITS = 5;
  localparam int DEF_HIST_BITS  = 5;

  // Wide enough for the tag at any INDEX_BITS >= 0
  localparam int TAG_W = 30;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

  localparam btb_entry_t RST_ENTRY = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    WNT
  };

endpackage

// File: rtl/btb_predictor_sat_counter2.sv
// Two-bit saturating counter next-state function.
module sat_counter2
  import btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken && ctr != ST)
      ctr_next = ctr + 2'd1;
    else if (!taken && ctr != SNT)
      ctr_next = ctr - 2'd1;
  end

endmodule

// File: rtl/btb_predictor.sv
// Gshare direction predictor with a tagged target buffer in IF;
// trained non-speculatively by branches resolved in EX.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int HIST_BITS  = DEF_HIST_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          current_pc,
  output logic                 prediction,
  output logic [31:0]          pre_pc,
  output logic [HIST_BITS-1:0] lookup_bhr,
  input  logic                 update_valid,
  input  logic [31:0]          update_pc,
  input  logic [HIST_BITS-1:0] update_bhr,
  input  logic                 update_taken,
  input  logic [31:0]          update_target
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LSB = INDEX_BITS + 2;

  btb_entry_t           tbl [ENTRIES];
  logic [HIST_BITS-1:0] bhr;

  function automatic logic [INDEX_BITS-1:0] idx_of(
    input logic [31:0]          pc,
    input logic [HIST_BITS-1:0] h
  );
    return pc[INDEX_BITS+1:2] ^ INDEX_BITS'(h);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
    return TAG_W'(pc >> TAG_LSB);
  endfunction

  logic                  unused_pc_lsb;
  assign unused_pc_lsb = ^{current_pc[1:0], update_pc[1:0]};

  logic [INDEX_BITS-1:0] lk_idx;
  btb_entry_t            lk;
  logic                  lk_hit;

  assign lk_idx     = idx_of(current_pc, bhr);
  assign lk         = tbl[lk_idx];
  assign lk_hit     = lk.valid && lk.tag == tag_of(current_pc);
  assign prediction = lk_hit && lk.ctr[1];
  assign pre_pc     = prediction ? lk.target : current_pc + 32'd4;
  assign lookup_bhr = bhr;

  logic [INDEX_BITS-1:0] up_idx;
  btb_entry_t            up;
  logic                  up_hit;
  logic [1:0]            ctr_nx;
  logic                  wr_en;
  btb_entry_t            wr_entry;

  assign up_idx = idx_of(update_pc, update_bhr);
  assign up     = tbl[up_idx];
  assign up_hit = up.valid && up.tag == tag_of(update_pc);

  sat_counter2 u_ctr (
    .ctr      (up.ctr),
    .taken    (update_taken),
    .ctr_next (ctr_nx)
  );

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = up;
    unique case (1'b1)
      up_hit: begin
        wr_en        = 1'b1;
        wr_entry.ctr = ctr_nx;
        if (update_taken)
          wr_entry.target = update_target;
      end
      (!up_hit && update_taken): begin
        wr_en    = 1'b1;
        wr_entry = '{
          valid:  1'b1,
          tag:    tag_of(update_pc),
          target: update_target,
          ctr:    WT
        };
      end
      default: ;
    endcase
  end

  // Reset wins over a coincident update; whole table clears in one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      bhr <= '0;
      for (int i = 0; i < ENTRIES; i++)
        tbl[i] <= RST_ENTRY;
    end else if (update_valid) begin
      bhr <= {bhr[HIST_BITS-2:0], update_taken};
      if (wr_en)
        tbl[up_idx] <= wr_entry;
    end
  end

endmodule
